// File: rtl/s1_fetch_unit_pkg.sv
// rtl/s1_fetch_unit_pkg.sv - shared pc_sel encodings and fetch constants
package s1_fetch_unit_pkg;

  // pc_sel encodings, shared with stage-3 control
  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_ALU   = 2'd1;
  localparam logic [1:0] PC_SEL_JAL   = 2'd2;
  localparam logic [1:0] PC_SEL_RST   = 2'd3;

  // BIOS base and the addi x0,x0,0 bubble
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h4000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // True when stage 3 is steering fetch to a branch/JALR or JAL target
  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PC_SEL_ALU) || (sel == PC_SEL_JAL);
  endfunction

endpackage

// File: rtl/s1_fetch_unit_pc_next_mux.sv
// rtl/s1_fetch_unit_pc_next_mux.sv - combinational next-PC priority select
module s1_fetch_unit_pc_next_mux
  import s1_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_target,
  input  logic [31:0] jal_target,
  input  logic        stall,
  input  logic [31:0] pc_f,
  output logic [31:0] next_pc
);

  // Reset vector first, then redirects, then stall hold, else sequential;
  // a redirect beats stall because the stalled instruction is wrong-path
  always_comb begin
    next_pc = pc_f + 32'd4;
    if (rst || pc_sel == PC_SEL_RST) begin
      next_pc = RESET_PC;
    end else if (pc_sel == PC_SEL_JAL) begin
      next_pc = jal_target;
    end else if (pc_sel == PC_SEL_ALU) begin
      next_pc = alu_target;
    end else if (stall) begin
      next_pc = pc_f;
    end
  end

endmodule

// File: rtl/s1_fetch_unit.sv
// rtl/s1_fetch_unit.sv - stage-1 fetch: PC register, memory addressing, stage-2 registers
module s1_fetch_unit
  import s1_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_target,
  input  logic [31:0] jal_target,
  input  logic        stall,
  input  logic [31:0] bios_dout,
  input  logic [31:0] imem_dout,
  output logic [11:0] bios_addr,
  output logic [13:0] imem_addr,
  output logic [31:0] pc_f,
  output logic [31:0] pc_s2,
  output logic [31:0] instr_s2,
  output logic        valid_s2,
  output logic        flush_s2
);

  logic [31:0] next_pc;
  logic [31:0] fetch_data;
  logic        any_redirect;

  s1_fetch_unit_pc_next_mux #(
    .RESET_PC (RESET_PC)
  ) u_pc_next_mux (
    .rst        (rst),
    .pc_sel     (pc_sel),
    .alu_target (alu_target),
    .jal_target (jal_target),
    .stall      (stall),
    .pc_f       (pc_f),
    .next_pc    (next_pc)
  );

  // Memories are synchronous-read, so they are addressed with next_pc;
  // low address bits of misaligned targets are simply dropped here
  assign bios_addr = next_pc[13:2];
  assign imem_addr = next_pc[15:2];

  // pc_f[30] distinguishes the BIOS window from IMEM
  assign fetch_data = pc_f[30] ? bios_dout : imem_dout;

  // pc_sel=3 also bubbles stage 2 but does not flush: stage 3 resets itself
  assign any_redirect = (pc_sel != PC_SEL_PLUS4);
  assign flush_s2     = !rst && is_redirect(pc_sel);

  // Fetch PC follows next_pc every cycle (the mux already handles hold/reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= next_pc;
    end
  end

  // Stage-2 registers: bubble on redirect, hold on stall, else capture fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_s2    <= '0;
      instr_s2 <= NOP_INSTR;
      valid_s2 <= 1'b0;
    end else if (any_redirect) begin
      pc_s2    <= pc_f;
      instr_s2 <= NOP_INSTR;
      valid_s2 <= 1'b0;
    end else if (!stall) begin
      pc_s2    <= pc_f;
      instr_s2 <= fetch_data;
      valid_s2 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_s1_fetch_unit.sv
// tb/tb_s1_fetch_unit.sv - self-checking bench for s1_fetch_unit
module tb_s1_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_sel = 2'd0;
  logic [31:0] alu_target = '0;
  logic [31:0] jal_target = '0;
  logic        stall = 1'b0;
  logic [31:0] bios_dout = '0;
  logic [31:0] imem_dout = '0;
  logic [11:0] bios_addr;
  logic [13:0] imem_addr;
  logic [31:0] pc_f;
  logic [31:0] pc_s2;
  logic [31:0] instr_s2;
  logic        valid_s2;
  logic        flush_s2;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] RV  = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  s1_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_sel     (pc_sel),
    .alu_target (alu_target),
    .jal_target (jal_target),
    .stall      (stall),
    .bios_dout  (bios_dout),
    .imem_dout  (imem_dout),
    .bios_addr  (bios_addr),
    .imem_addr  (imem_addr),
    .pc_f       (pc_f),
    .pc_s2      (pc_s2),
    .instr_s2   (instr_s2),
    .valid_s2   (valid_s2),
    .flush_s2   (flush_s2)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is distinguishable by its address
  function automatic logic [31:0] bios_word(input logic [11:0] a);
    return (a == 12'd0) ? 32'h0000_0093 : {20'hB1051, a};
  endfunction

  function automatic logic [31:0] imem_word(input logic [13:0] a);
    return {18'h2AAAA, a};
  endfunction

  // Instruction that architecturally lives at byte address pc
  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    return pc[30] ? bios_word(pc[13:2]) : imem_word(pc[15:2]);
  endfunction

  // Synchronous-read memories
  always @(posedge clk) begin
    bios_dout <= bios_word(bios_addr);
    imem_dout <= imem_word(imem_addr);
  end

  // Behavioural model state
  logic [31:0] m_pc, m_pc_s2, m_instr;
  logic        m_valid;
  logic        m_known = 1'b0;

  function automatic logic [31:0] model_target();
    if (rst || pc_sel == 2'd3) return RV;
    if (pc_sel == 2'd2) return jal_target;
    if (pc_sel == 2'd1) return alu_target;
    if (stall) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare();
    logic [31:0] t;
    t = model_target();
    chk("bios_addr", {20'd0, bios_addr}, {20'd0, t[13:2]});
    chk("imem_addr", {18'd0, imem_addr}, {18'd0, t[15:2]});
    chk("flush_s2", {31'd0, flush_s2}, {31'd0, (!rst && (pc_sel == 2'd1 || pc_sel == 2'd2))});
    if (m_known) begin
      chk("pc_f", pc_f, m_pc);
      chk("pc_s2", pc_s2, m_pc_s2);
      chk("instr_s2", instr_s2, m_instr);
      chk("valid_s2", {31'd0, valid_s2}, {31'd0, m_valid});
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] j, input logic st);
    rst = r; pc_sel = s; alu_target = a; jal_target = j; stall = st;
    #1;
    compare();
  endtask

  // Advance one clock and update the model with the inputs of that cycle
  task automatic tick();
    logic [31:0] t;
    @(posedge clk);
    t = model_target();
    if (rst) begin
      m_pc_s2 = '0; m_instr = NOP; m_valid = 1'b0;
    end else if (pc_sel != 2'd0) begin
      m_pc_s2 = m_pc; m_instr = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      m_pc_s2 = m_pc; m_instr = mem_at(m_pc); m_valid = 1'b1;
    end
    m_pc = t;
    m_known = 1'b1;
    @(negedge clk);
  endtask

  task automatic free_run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 2'd0, '0, '0, 0);
      tick();
    end
  endtask

  initial begin
    m_pc = RV; m_pc_s2 = '0; m_instr = NOP; m_valid = 1'b0;

    // Reset for two cycles
    drive(1, 2'd0, '0, '0, 0); tick();
    drive(1, 2'd0, '0, '0, 0); tick();

    // Cycle 1 after reset
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_rst_pc_f", pc_f, 32'h4000_0000);
    chk("lit_rst_pc_s2", pc_s2, 32'h0);
    chk("lit_rst_instr", instr_s2, 32'h13);
    chk("lit_rst_valid", {31'd0, valid_s2}, 32'd0);
    chk("lit_c1_bios_addr", {20'd0, bios_addr}, 32'h001);
    tick();

    // Cycle 2: first instruction reaches stage 2
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_c2_instr", instr_s2, 32'h0000_0093);
    chk("lit_c2_valid", {31'd0, valid_s2}, 32'd1);
    chk("lit_c2_pc_s2", pc_s2, 32'h4000_0000);
    chk("lit_c2_pc_f", pc_f, 32'h4000_0004);
    chk("lit_c2_bios_addr", {20'd0, bios_addr}, 32'h002);
    tick();

    // Stall three cycles at 0x4000_0008
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'd0, '0, '0, 1);
      chk("lit_stall_pc_f", pc_f, 32'h4000_0008);
      chk("lit_stall_bios_addr", {20'd0, bios_addr}, 32'h002);
      chk("lit_stall_pc_s2", pc_s2, 32'h4000_0004);
      tick();
    end
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_release_bios_addr", {20'd0, bios_addr}, 32'h003);
    tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_resume_pc_f", pc_f, 32'h4000_000C);
    chk("lit_resume_bios_addr", {20'd0, bios_addr}, 32'h004);
    tick();

    // ALU redirect into IMEM
    drive(0, 2'd1, 32'h1000_0040, '0, 0);
    chk("lit_redir_flush", {31'd0, flush_s2}, 32'd1);
    chk("lit_redir_imem_addr", {18'd0, imem_addr}, 32'h010);
    tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_n1_pc_f", pc_f, 32'h1000_0040);
    chk("lit_n1_instr", instr_s2, 32'h13);
    chk("lit_n1_valid", {31'd0, valid_s2}, 32'd0);
    tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_n2_instr", instr_s2, 32'hAAAA_8010);
    chk("lit_n2_valid", {31'd0, valid_s2}, 32'd1);
    tick();

    // JAL redirect together with stall
    drive(0, 2'd2, '0, 32'h4000_0100, 1);
    chk("lit_jalstall_flush", {31'd0, flush_s2}, 32'd1);
    tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_jalstall_pc_f", pc_f, 32'h4000_0100);
    chk("lit_jalstall_valid", {31'd0, valid_s2}, 32'd0);
    tick();
    free_run(2);

    // Back-to-back redirects, first one misaligned
    drive(0, 2'd1, 32'h1000_0003, '0, 0); tick();
    drive(0, 2'd2, '0, 32'h4000_0200, 0);
    chk("lit_b2b_misaligned_pc_f", pc_f, 32'h1000_0003);
    chk("lit_b2b_valid1", {31'd0, valid_s2}, 32'd0);
    tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_b2b_pc_f", pc_f, 32'h4000_0200);
    chk("lit_b2b_valid2", {31'd0, valid_s2}, 32'd0);
    tick();
    free_run(2);

    // pc_sel=3 outside reset
    drive(0, 2'd3, 32'h1234_5678, 32'h8765_4320, 0);
    chk("lit_sel3_flush", {31'd0, flush_s2}, 32'd0);
    tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_sel3_pc_f", pc_f, 32'h4000_0000);
    chk("lit_sel3_valid", {31'd0, valid_s2}, 32'd0);
    tick();
    free_run(2);

    // Reset during stall at 0x4000_0020
    drive(0, 2'd2, '0, 32'h4000_0020, 0); tick();
    drive(0, 2'd0, '0, '0, 1);
    chk("lit_pre_rst_pc_f", pc_f, 32'h4000_0020);
    tick();
    drive(1, 2'd1, 32'h1000_0000, '0, 1);
    chk("lit_rst_flush", {31'd0, flush_s2}, 32'd0);
    tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_midrst_pc_f", pc_f, 32'h4000_0000);
    chk("lit_midrst_instr", instr_s2, 32'h13);
    chk("lit_midrst_valid", {31'd0, valid_s2}, 32'd0);
    tick();
    free_run(1);

    // PC wrap at the top of the address space
    drive(0, 2'd1, 32'hFFFF_FFFC, '0, 0); tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_wrap_pre", pc_f, 32'hFFFF_FFFC);
    tick();
    drive(0, 2'd0, '0, '0, 0);
    chk("lit_wrap_post", pc_f, 32'h0000_0000);
    tick();
    free_run(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s1_fetch_unit.md
Name: s1_fetch_unit

Overview:
Front end of the 3-stage core. It is the receiving end of the stage-3 `pc_sel` redirect interface.
- Holds the fetch PC and computes the next PC from `pc_sel` and the redirect targets.
- Drives the synchronous-read BIOS and IMEM address ports, and selects the returned instruction.
- Registers the instruction into stage 2, inserting a bubble (NOP, `valid_s2`=0) on redirect.
- Honors a stage-2 stall by holding the PC and the stage-2 registers.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset / `pc_sel`=3 (BIOS base).
- NOP_INSTR, 32'h0000_0013, `addi x0,x0,0` used as the bubble.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_sel  in  2  redirect select from stage 3: 0=PC+4, 1=`alu_target` (branch/JALR), 2=`jal_target`, 3=reset vector.
- alu_target  in  32  branch/JALR target from stage-3 ALU.
- jal_target  in  32  forwarded JAL target.
- stall  in  1  stage 2 cannot accept; hold.
- bios_dout  in  32  BIOS read data (address presented previous cycle).
- imem_dout  in  32  IMEM read data (address presented previous cycle).
- bios_addr  out  12  BIOS word address = `next_pc[13:2]`.
- imem_addr  out  14  IMEM word address = `next_pc[15:2]`.
- pc_f  out  32  PC of the instruction currently returned by memory.
- pc_s2  out  32  PC of the instruction in stage 2.
- instr_s2  out  32  stage-2 instruction.
- valid_s2  out  1  stage-2 instruction is architectural (not a bubble).
- flush_s2  out  1  combinational; high when `pc_sel` is 1 or 2 and not `rst`; stage 2 must squash its s2→s3 transfer.

Behaviour:
- Reset: `pc_f`=RESET_PC, `pc_s2`=0, `instr_s2`=NOP_INSTR, `valid_s2`=0.
- During `rst`, `next_pc`=RESET_PC, so the first cycle after reset already has the RESET_PC instruction on `*_dout`.
- `next_pc` priority:
  - `rst` or `pc_sel`=3 → RESET_PC
  - `pc_sel`=2 → `jal_target`
  - `pc_sel`=1 → `alu_target`
  - `stall` → `pc_f` (re-present the same address so the memory output holds)
  - else `pc_f`+4, mod 2^32 (wrap silently).
- Redirect beats stall: the stalled instruction is wrong-path.
- `pc_f` <= `next_pc` every cycle.
- Fetch-data select is combinational from `pc_f`: `pc_f[30]`=1 → `bios_dout`, else `imem_dout`.
- Stage-2 register update:
  - `rst` → reset values.
  - Redirect (`pc_sel` 1/2) → `instr_s2`=NOP_INSTR, `valid_s2`=0, `pc_s2`=`pc_f`.
  - `stall` (no redirect) → hold all three.
  - Else → `instr_s2`=selected data, `pc_s2`=`pc_f`, `valid_s2`=1.
- Redirect latency: redirect in cycle N → target on `bios_addr`/`imem_addr` in N, `pc_f`=target in N+1, target instruction in `instr_s2` at N+2. Exactly one bubble in s2 (at N+1); the s2 instruction at N is squashed via `flush_s2`.
- Back-to-back redirects: each one overrides; a bubble is inserted each cycle.
- `pc_sel`=3 while not in reset: treated as reset vector for PC only. Stage-2 registers load a bubble and `flush_s2`=0 (stage 3 also resets).
- `rst` mid-stall or mid-redirect: reset wins in the same cycle.
- Misaligned targets (`target[1:0]`≠0): low bits pass into `pc_f`; addresses ignore them. No trap.

Decomposition:
- Shared header: `PC_SEL_PLUS4`/`PC_SEL_ALU`/`PC_SEL_JAL`/`PC_SEL_RST` encodings (shared with stage-3 control), RESET_PC, NOP_INSTR.
- One natural sub-module: `pc_next_mux` (combinational next-PC priority logic). Registers stay in the top module.

Test Plan:
- Reset then release with BIOS model returning `0x00000093` at 0x4000_0000:
  - cycle 1 → `pc_f`=0x4000_0000, `bios_addr`=0x001;
  - cycle 2 → `instr_s2`=0x00000093, `valid_s2`=1, `pc_s2`=0x4000_0000.
- Free-run 4 cycles with `pc_sel`=0 → `pc_f` = 0x4000_0000, _04, _08, _0C; `bios_addr` = 1, 2, 3, 4.
- `pc_sel`=1, `alu_target`=0x1000_0040 at cycle N:
  - N: `flush_s2`=1, `imem_addr`=0x010;
  - N+1: `pc_f`=0x1000_0040, `instr_s2`=0x13, `valid_s2`=0;
  - N+2: `instr_s2`=IMEM[0x10], `valid_s2`=1.
- `stall`=1 for 3 cycles at `pc_f`=0x4000_0008 → `pc_f`, `pc_s2`, `instr_s2` all unchanged; `bios_addr` held at 0x002; resumes at _0C on release.
- `stall`=1 and `pc_sel`=2 (`jal_target`=0x4000_0100) together → next `pc_f`=0x4000_0100, `valid_s2`=0.
- `rst` asserted during stall with `pc_f`=0x4000_0020 → next cycle `pc_f`=0x4000_0000, `instr_s2`=0x13, `valid_s2`=0; `pc_f`+4 wrap: `pc_f`=0xFFFF_FFFC → 0x0000_0000.
